phase_sequencer: RTL and testbench
==================================

// Module: phase_sequencer
// PURPOSE
//  Generates the 3-bit instruction phase (0..7) that drives the combinational
//  control decoder, and the datapath clock enable. Inserts memory wait states,
//  freezes the CPU on HALT, supports run/single-step resume and counts retired
//  instructions. Sits between the debug/memory interfaces and the decoder.
// PARAMETERS
//  IC_W         16  width of instr_count
//  MAX_WAIT     15  consecutive stall cycles tolerated before fault (>=1)
//  START_HALTED 0   1: leave reset in HALTED at phase 0; 0: leave reset in RUN
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     async active-high reset
//  halt         in   1     decoder halt request (valid in phase 4)
//  rd           in   1     decoder memory read strobe
//  wr           in   1     decoder memory write strobe
//  mem_ready    in   1     memory done this cycle; ignored when rd=wr=0
//  run_req      in   1     resume free-running (level, sampled each clk)
//  step_req     in   1     execute one instruction from HALTED
//  phase        out  3     current phase to decoder (registered)
//  cycle_en     out  1     datapath register enable (combinational)
//  state        out  2     0 RUN, 1 HALTED, 2 STEP, 3 FAULT (registered)
//  fault        out  1     state==FAULT
//  instr_count  out  IC_W  retired instructions, wraps modulo 2^IC_W
// BEHAVIOUR
//  Reset: phase=0, instr_count=0, wait_cnt=0, state=START_HALTED?HALTED:RUN.
//  stall = (rd|wr) & ~mem_ready.
//  cycle_en = (state==RUN|state==STEP) & ~stall. Zero in HALTED and FAULT.
//  RUN/STEP, cycle_en=1: phase <= phase+1 (7 wraps to 0); wait_cnt <= 0.
//  RUN/STEP, stall: phase held, wait_cnt <= wait_cnt+1 (saturating).
//  Phase 4 with cycle_en=1: RUN & halt=1 -> HALTED; STEP -> HALTED whatever
//   halt is. Phase is held at 4 (not advanced); the phase-4 cycle itself is
//   enabled, so the PC increment commits exactly once.
//  HALTED: phase held, cycle_en=0. run_req=1 -> RUN, phase <= phase+1.
//   Else step_req=1 -> STEP, phase <= phase+1. run_req has priority.
//   Advancing out of 4 on resume guarantees no immediate re-halt.
//  STEP: runs the phases 5,6,7,0..4 as in RUN; run_req/step_req ignored.
//  instr_count += 1 on each phase 7->0 advance (cycle_en=1); in wrap
//   to 0 at 2^IC_W-1. Never counts on stalled or halted cycles.
//  FAULT: phase, instr_count frozen; cycle_en=0; exits only on rst.
//  Async rst mid-stall or mid-step: all state returns to reset values at once.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: in RUN/STEP, a stall cycle with wait_cnt==MAX_WAIT-1
//   moves to FAULT at that edge (MAX_WAIT stall cycles total); mem_ready
//   arriving on that same cycle wins (no stall, no fault).
//  Not defined: stalls last indefinitely, wait_cnt absent, FAULT unreachable,
//   fault tied 0.
// TESTING
//  Reset, START_HALTED=0, rd=wr=0, halt=0 -> phase 0..7,0 over 8 clks,
//   cycle_en=1 each, instr_count=1 after 8th edge.
//  rd=1 in phase 1, mem_ready low 3 clks -> phase stays 1 for 3 clks,
//   cycle_en=0; advances to 2 on the edge mem_ready=1.
//  halt=1 at phase 4 -> state=HALTED, phase=4, cycle_en=0 for 10 clks;
//   run_req pulse -> phase=5, state=RUN, no second halt.
//  HALTED at 4, step_req pulse -> 8 enabled cycles 5,6,7,0,1,2,3,4, then
//   HALTED at 4, instr_count +1, halt=0 throughout.
//  SEQ_TIMEOUT_EN, MAX_WAIT=15, rd=1, mem_ready=0 -> FAULT after 15 stall
//   clks, fault=1; rst -> phase 0, fault 0. With ready on 15th clk: no fault.
//  IC_W=4, run 16 instructions -> instr_count wraps 15->0.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: produces the 3-bit instruction phase for the control decoder
// and the datapath clock enable. It inserts memory wait states, freezes on
// HALT, resumes by run or single step, and counts retired instructions.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   : a memory stall of MAX_WAIT consecutive cycles moves to FAULT.
//   undefined : stalls last indefinitely, FAULT is unreachable, o_fault is 0.
//
// Handshake: a memory access is requested whenever i_rd or i_wr is high. It
// completes in the cycle that i_mem_ready is high. While a request is
// outstanding and i_mem_ready is low, the cycle is a stall: the phase holds
// and o_cycle_en is low. i_mem_ready is ignored when no request is present.
module phase_sequencer #(
    parameter int IC_W         = 16,
    parameter int MAX_WAIT     = 15,
    parameter bit START_HALTED = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_halt,
    input  logic            i_rd,
    input  logic            i_wr,
    input  logic            i_mem_ready,
    input  logic            i_run_req,
    input  logic            i_step_req,
    output logic [2:0]      o_phase,
    output logic            o_cycle_en,
    output logic [1:0]      o_state,
    output logic            o_fault,
    output logic [IC_W-1:0] o_instr_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    // The phase in which the decoder presents halt and the PC increment commits
    localparam logic [2:0] HALT_PHASE = 3'd4;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_phase;
    logic [2:0]      w_phase_nxt;
    logic [IC_W-1:0] r_count;
    logic [IC_W-1:0] w_count_nxt;
    logic            w_stall;
    logic            w_active;

`ifdef SEQ_TIMEOUT_EN
    localparam int WC_W = $clog2(MAX_WAIT + 1);
    logic [WC_W-1:0] r_wait;
    logic [WC_W-1:0] w_wait_nxt;
`endif

    // A stall exists only while an access is outstanding and memory is not done
    always_comb begin
        w_stall    = (i_rd | i_wr) & ~i_mem_ready;
        w_active   = (r_state == ST_RUN) || (r_state == ST_STEP);
        o_cycle_en = w_active & ~w_stall;
    end

    // State, phase, retired count and wait counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if (START_HALTED) begin
                r_state <= ST_HALTED;
            end else begin
                r_state <= ST_RUN;
            end
            r_phase <= 3'd0;
            r_count <= '0;
`ifdef SEQ_TIMEOUT_EN
            r_wait  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_count <= w_count_nxt;
`ifdef SEQ_TIMEOUT_EN
            r_wait  <= w_wait_nxt;
`endif
        end
    end

    // Next-state logic: advance, stall, halt at phase 4, resume, fault
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_count_nxt = r_count;
`ifdef SEQ_TIMEOUT_EN
        w_wait_nxt  = r_wait;
`endif
        case (r_state)
            ST_RUN, ST_STEP: begin
                if (!w_stall) begin
`ifdef SEQ_TIMEOUT_EN
                    w_wait_nxt = '0;
`endif
                    // The phase-4 cycle is enabled, but the phase holds at 4
                    // so that the PC increment commits exactly once.
                    if ((r_phase == HALT_PHASE) && ((r_state == ST_STEP) || i_halt)) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_phase_nxt = r_phase + 3'd1;
                        if (r_phase == 3'd7) begin
                            w_count_nxt = r_count + IC_W'(1);
                        end
                    end
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (r_wait == WC_W'(MAX_WAIT - 1)) begin
                        w_state_nxt = ST_FAULT;
                    end
                    if (r_wait != '1) begin
                        w_wait_nxt = r_wait + WC_W'(1);
                    end
`endif
                end
            end
            ST_HALTED: begin
                // Leaving by advancing past phase 4 prevents an immediate re-halt
                if (i_run_req) begin
                    w_state_nxt = ST_RUN;
                    w_phase_nxt = r_phase + 3'd1;
                end else if (i_step_req) begin
                    w_state_nxt = ST_STEP;
                    w_phase_nxt = r_phase + 3'd1;
                end
            end
            default: begin
                // FAULT: everything frozen until reset
            end
        endcase
    end

    // Registered outputs
    always_comb begin
        o_phase       = r_phase;
        o_state       = r_state;
        o_instr_count = r_count;
`ifdef SEQ_TIMEOUT_EN
        o_fault       = (r_state == ST_FAULT);
`else
        o_fault       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed test of phase_sequencer with IC_W=4 so the
// retired-instruction counter wrap can be reached in a short run.
module tb_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       halt;
    logic       rd;
    logic       wr;
    logic       mem_ready;
    logic       run_req;
    logic       step_req;
    logic [2:0] phase;
    logic       cycle_en;
    logic [1:0] state;
    logic       fault;
    logic [3:0] instr_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    phase_sequencer #(
        .IC_W        (4),
        .MAX_WAIT    (15),
        .START_HALTED(1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_halt       (halt),
        .i_rd         (rd),
        .i_wr         (wr),
        .i_mem_ready  (mem_ready),
        .i_run_req    (run_req),
        .i_step_req   (step_req),
        .o_phase      (phase),
        .o_cycle_en   (cycle_en),
        .o_state      (state),
        .o_fault      (fault),
        .o_instr_count(instr_count)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; rd = 1'b0; wr = 1'b0;
        mem_ready = 1'b0; run_req = 1'b0; step_req = 1'b0;
        #12;
        // reset state
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_cycle_en", 32'(cycle_en), 32'd1);

        // free run through a full instruction
        for (int i = 1; i <= 8; i++) begin
            chk("run_cycle_en", 32'(cycle_en), 32'd1);
            tick();
            chk("run_phase", 32'(phase), 32'(i % 8));
        end
        chk("run_count", 32'(instr_count), 32'd1);

        // read stall in phase 1 for 3 cycles
        tick();
        chk("pre_stall_phase", 32'(phase), 32'd1);
        rd = 1'b1;
        #1;
        chk("stall_cycle_en", 32'(cycle_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_phase", 32'(phase), 32'd1);
            chk("stall_cycle_en_hold", 32'(cycle_en), 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("ready_cycle_en", 32'(cycle_en), 32'd1);
        tick();
        chk("ready_phase", 32'(phase), 32'd2);
        rd = 1'b0; mem_ready = 1'b0;
        // write stall, one cycle
        wr = 1'b1;
        #1;
        chk("wr_stall_cycle_en", 32'(cycle_en), 32'd0);
        tick();
        chk("wr_stall_phase", 32'(phase), 32'd2);
        wr = 1'b0;
        #1;
        chk("stall_count", 32'(instr_count), 32'd1);

        // halt at phase 4
        tick();
        tick();
        chk("halt_pre_phase", 32'(phase), 32'd4);
        halt = 1'b1;
        #1;
        chk("halt_phase4_en", 32'(cycle_en), 32'd1);
        tick();
        chk("halt_state", 32'(state), 32'd1);
        chk("halt_phase", 32'(phase), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halted_phase", 32'(phase), 32'd4);
            chk("halted_state", 32'(state), 32'd1);
            chk("halted_cycle_en", 32'(cycle_en), 32'd0);
        end
        chk("halted_count", 32'(instr_count), 32'd1);
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        #1;
        chk("resume_phase", 32'(phase), 32'd5);
        chk("resume_state", 32'(state), 32'd0);
        chk("resume_cycle_en", 32'(cycle_en), 32'd1);
        halt = 1'b0;
        repeat (7) tick();
        chk("lap_phase", 32'(phase), 32'd4);
        chk("lap_count", 32'(instr_count), 32'd2);
        tick();
        chk("no_halt_phase", 32'(phase), 32'd5);
        chk("no_halt_state", 32'(state), 32'd0);
        repeat (7) tick();
        chk("lap2_count", 32'(instr_count), 32'd3);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt2_state", 32'(state), 32'd1);
        chk("halt2_phase", 32'(phase), 32'd4);

        // single step
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        #1;
        chk("step_state", 32'(state), 32'd2);
        chk("step_phase", 32'(phase), 32'd5);
        for (int i = 0; i < 7; i++) begin
            run_req = (i == 2);
            #1;
            chk("step_cycle_en", 32'(cycle_en), 32'd1);
            tick();
            chk("step_walk_phase", 32'(phase), 32'((6 + i) % 8));
            chk("step_walk_state", 32'(state), 32'd2);
        end
        run_req = 1'b0;
        chk("step_count", 32'(instr_count), 32'd4);
        tick();
        chk("step_end_state", 32'(state), 32'd1);
        chk("step_end_phase", 32'(phase), 32'd4);
        chk("step_end_cycle_en", 32'(cycle_en), 32'd0);
        chk("step_end_count", 32'(instr_count), 32'd4);

        // run_req has priority over step_req
        run_req = 1'b1; step_req = 1'b1;
        tick();
        run_req = 1'b0; step_req = 1'b0;
        chk("prio_state", 32'(state), 32'd0);
        chk("prio_phase", 32'(phase), 32'd5);

        // counter wrap with IC_W=4
        for (int k = 0; k < 12; k++) begin
            repeat (8) tick();
            chk("wrap_count", 32'(instr_count), 32'((5 + k) % 16));
        end

        // async reset in the middle of a stall
        rd = 1'b1;
        tick();
        tick();
        chk("mid_stall_phase", 32'(phase), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_phase", 32'(phase), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_count", 32'(instr_count), 32'd0);
        #1;
        rst = 1'b0;

`ifdef SEQ_TIMEOUT_EN
        // timeout: 15 stall cycles lead to FAULT
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("to_state", 32'(state), 32'd0);
            chk("to_fault", 32'(fault), 32'd0);
        end
        tick();
        chk("to_fault_state", 32'(state), 32'd3);
        chk("to_fault_flag", 32'(fault), 32'd1);
        chk("to_fault_cycle_en", 32'(cycle_en), 32'd0);
        rd = 1'b0;
        repeat (3) tick();
        chk("fault_hold_state", 32'(state), 32'd3);
        chk("fault_hold_phase", 32'(phase), 32'd0);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("fault_rst_fault", 32'(fault), 32'd0);
        chk("fault_rst_phase", 32'(phase), 32'd0);
        // ready arriving on the 15th cycle wins
        rd = 1'b1;
        repeat (14) tick();
        mem_ready = 1'b1;
        #1;
        tick();
        chk("late_ready_state", 32'(state), 32'd0);
        chk("late_ready_fault", 32'(fault), 32'd0);
        chk("late_ready_phase", 32'(phase), 32'd1);
        rd = 1'b0; mem_ready = 1'b0;
`else
        // without timeout a long stall never faults
        repeat (20) tick();
        chk("long_stall_fault", 32'(fault), 32'd0);
        chk("long_stall_state", 32'(state), 32'd0);
        chk("long_stall_phase", 32'(phase), 32'd0);
        mem_ready = 1'b1;
        tick();
        chk("long_stall_release", 32'(phase), 32'd1);
        rd = 1'b0; mem_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
